// File: rtl/msj_setpoint_manager.sv
// Per-motor setpoint manager: Avalon-MM target registers, jog buttons, rate-limited clamped setpoints.
// Latency: reads take 2 cycles, writes 1; setpoints move only on ramp ticks.
// Backpressure: waitrequest is held for the first cycle of every read; writes are never stalled.
module msj_setpoint_manager #(
    parameter int NUMBER_OF_MOTORS   = 8,
    parameter int SP_WIDTH           = 32,
    parameter int DEFAULT_STEP       = 10,
    parameter int REPEAT_CYCLES      = 65536,
    parameter int RAMP_PERIOD_CYCLES = 50000,
    parameter int WATCHDOG_CYCLES    = 50000000
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [15:0]                          address,
    input  logic                                 write,
    input  logic [31:0]                          writedata,
    input  logic                                 read,
    output logic [31:0]                          readdata,
    output logic                                 waitrequest,
    input  logic                                 emergency_off,
    input  logic [NUMBER_OF_MOTORS-1:0]          pull_buttons,
    input  logic [NUMBER_OF_MOTORS-1:0]          release_buttons,
    input  logic                                 pull_all_button,
    input  logic                                 release_all_button,
    input  logic                                 zero_pose_button,
    output logic [NUMBER_OF_MOTORS*SP_WIDTH-1:0] sp_out,
    output logic [NUMBER_OF_MOTORS-1:0]          sp_valid,
    output logic [1:0]                           faults
);

    localparam int N  = NUMBER_OF_MOTORS;
    localparam int W  = SP_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef logic signed [W-1:0] sp_t;
    typedef logic signed [W:0]   wide_t;

    localparam sp_t         SP_LO     = {1'b1, {(W-1){1'b0}}};
    localparam sp_t         SP_HI     = {1'b0, {(W-1){1'b1}}};
    localparam logic [31:0] RAMP_LAST = 32'(RAMP_PERIOD_CYCLES - 1);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);
    localparam logic [31:0] WD_LAST   = 32'(WATCHDOG_CYCLES - 1);

    function automatic wide_t sx(input sp_t x);
        return {x[W-1], x};
    endfunction

    // Saturate to the representable range, then apply max before min so an inverted window yields min.
    function automatic sp_t sat_clamp(input wide_t v, input sp_t lo, input sp_t hi);
        sp_t s;
        if (v > sx(SP_HI))
            s = SP_HI;
        else if (v < sx(SP_LO))
            s = SP_LO;
        else
            s = v[W-1:0];
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    logic [7:0]    reg_sel;
    logic [7:0]    ch;
    logic [CW-1:0] ch_idx;
    logic          ch_ok;
    logic          ack;
    logic [31:0]   rd_value;
    logic [31:0]   ramp_cnt;
    logic [31:0]   rep_cnt;
    logic [31:0]   wd_cnt;
    logic          wd_en;
    logic          ramp_tick;
    logic          sp_upd;
    logic          fault_any;
    logic          all_up;
    logic          all_dn;
    logic          wr_ctrl;
    logic          wd_fire;
    logic [N-1:0]  pull_prev;
    logic [N-1:0]  rel_prev;

    sp_t        target_a [N];
    sp_t        sp_a     [N];
    logic [W-1:0] slew_a [N];
    sp_t        min_a    [N];
    sp_t        max_a    [N];
    sp_t        step_a   [N];

    assign reg_sel     = address[15:8];
    assign ch          = address[7:0];
    assign ch_idx      = ch[CW-1:0];
    assign ch_ok       = (32'(ch) < 32'(N));
    assign waitrequest = read && !ack && !reset;
    assign fault_any   = |faults;
    assign ramp_tick   = (ramp_cnt == RAMP_LAST);
    assign sp_upd      = ramp_tick && !fault_any;
    assign all_up      = (rep_cnt == '0) && !pull_all_button && release_all_button;
    assign all_dn      = (rep_cnt == '0) && !release_all_button && pull_all_button;
    assign wr_ctrl     = write && (reg_sel == 8'h06);
    assign wd_fire     = wd_en && !write && (wd_cnt == WD_LAST);

    always_comb begin
        rd_value = 32'hDEAD_BEEF;
        case (reg_sel)
            8'h00: if (ch_ok) rd_value = 32'(target_a[ch_idx]);
            8'h01: if (ch_ok) rd_value = 32'(sp_a[ch_idx]);
            8'h02: if (ch_ok) rd_value = 32'(slew_a[ch_idx]);
            8'h03: if (ch_ok) rd_value = 32'(min_a[ch_idx]);
            8'h04: if (ch_ok) rd_value = 32'(max_a[ch_idx]);
            8'h05: if (ch_ok) rd_value = 32'(step_a[ch_idx]);
            8'h06: rd_value = {31'b0, wd_en};
            8'h07: rd_value = {30'b0, faults};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack       <= 1'b0;
            readdata  <= '0;
            faults    <= '0;
            wd_en     <= 1'b0;
            wd_cnt    <= '0;
            ramp_cnt  <= '0;
            rep_cnt   <= '0;
            pull_prev <= '1;
            rel_prev  <= '1;
        end else begin
            ack <= read && !ack;
            if (read && !ack)
                readdata <= rd_value;
            ramp_cnt  <= ramp_tick ? '0 : ramp_cnt + 32'd1;
            rep_cnt   <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 32'd1;
            pull_prev <= pull_buttons;
            rel_prev  <= release_buttons;
            if (wr_ctrl)
                wd_en <= writedata[0];
            if (!wd_en || write || wd_cnt == WD_LAST)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 32'd1;
            // Set conditions are ordered last so a live stop or expiry beats a clear in the same cycle.
            if (wr_ctrl && writedata[1]) begin
                faults[1] <= 1'b0;
                if (!emergency_off)
                    faults[0] <= 1'b0;
            end
            if (emergency_off)
                faults[0] <= 1'b1;
            if (wd_fire)
                faults[1] <= 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        sp_t          target_q;
        sp_t          sp_q;
        sp_t          min_q;
        sp_t          max_q;
        sp_t          step_q;
        logic [W-1:0] slew_q;
        logic         vld_q;
        sp_t          tgt_next;
        sp_t          sp_next;
        wide_t        diff;
        wide_t        mag;
        wide_t        slew_w;
        wide_t        moved;
        logic         hit;
        logic         pull_edge;
        logic         rel_edge;

        assign hit       = write && (32'(ch) == 32'(i));
        assign pull_edge = pull_prev[i] && !pull_buttons[i];
        assign rel_edge  = rel_prev[i] && !release_buttons[i];

        // With no update source the target is re-clamped, so limit writes take effect at once.
        always_comb begin
            tgt_next = sat_clamp(sx(target_q), min_q, max_q);
            if (fault_any)
                tgt_next = sp_q;
            else if (!zero_pose_button)
                tgt_next = sat_clamp('0, min_q, max_q);
            else if (hit && reg_sel == 8'h00)
                tgt_next = sat_clamp(sx(writedata[W-1:0]), min_q, max_q);
            else if (all_up)
                tgt_next = sat_clamp(sx(target_q) + sx(step_q), min_q, max_q);
            else if (all_dn)
                tgt_next = sat_clamp(sx(target_q) - sx(step_q), min_q, max_q);
            else if (pull_edge && !rel_edge)
                tgt_next = sat_clamp(sx(target_q) + sx(step_q), min_q, max_q);
            else if (rel_edge && !pull_edge)
                tgt_next = sat_clamp(sx(target_q) - sx(step_q), min_q, max_q);
        end

        always_comb begin
            diff    = sx(target_q) - sx(sp_q);
            mag     = (diff < 0) ? -diff : diff;
            slew_w  = {1'b0, slew_q};
            moved   = (diff < 0) ? sx(sp_q) - slew_w : sx(sp_q) + slew_w;
            sp_next = target_q;
            if (slew_q != '0 && mag > slew_w)
                sp_next = moved[W-1:0];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                target_q <= '0;
                sp_q     <= '0;
                slew_q   <= '0;
                min_q    <= SP_LO;
                max_q    <= SP_HI;
                step_q   <= sp_t'(DEFAULT_STEP);
                vld_q    <= 1'b0;
            end else begin
                target_q <= tgt_next;
                if (hit && reg_sel == 8'h02) slew_q <= writedata[W-1:0];
                if (hit && reg_sel == 8'h03) min_q  <= writedata[W-1:0];
                if (hit && reg_sel == 8'h04) max_q  <= writedata[W-1:0];
                if (hit && reg_sel == 8'h05) step_q <= writedata[W-1:0];
                vld_q <= sp_upd && (sp_next != sp_q);
                if (sp_upd)
                    sp_q <= sp_next;
            end
        end

        assign target_a[i]        = target_q;
        assign sp_a[i]            = sp_q;
        assign slew_a[i]          = slew_q;
        assign min_a[i]           = min_q;
        assign max_a[i]           = max_q;
        assign step_a[i]          = step_q;
        assign sp_out[i*W +: W]   = sp_q;
        assign sp_valid[i]        = vld_q;
    end

endmodule
